// File: rtl/tpu_pkg.sv
// Shared definitions for the operand feeder of the NxN PE array.
//   feeder_state_t : feeder FSM encoding
//   FEED_WIDTH     : default signed operand width
//   FEED_N         : default array dimension
//   STREAM_LEN     : wavefront cycles for FEED_N (2N-1)
//   DRAIN_LEN      : propagation + c_out register cycles for FEED_N (N)
//   operand_t      : signed operand of FEED_WIDTH bits
//   stream_len/drain_len : the same lengths for an arbitrary N
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

    localparam int FEED_WIDTH = 8;
    localparam int FEED_N     = 2;
    localparam int STREAM_LEN = 2 * FEED_N - 1;
    localparam int DRAIN_LEN  = FEED_N;

    typedef logic signed [FEED_WIDTH-1:0] operand_t;

    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int drain_len(input int n);
        return n;
    endfunction

endpackage

// File: rtl/systolic_feeder_operand_bank.sv
// NxN operand register file with one write port and N diagonally skewed
// read lanes.
//   clk, rst : clock and synchronous active-high reset (clears every element)
//   we       : write enable; waddr is row-major r*N+c, out-of-range is dropped
//   wdata    : element value
//   t        : wavefront index
//   lanes    : lane l (bits l*WIDTH +: WIDTH) holds the element at k = t-l,
//              or 0 when that k falls outside 0..N-1.
//              TRANSPOSE=0 -> M[l][k] (row-wise, A side)
//              TRANSPOSE=1 -> M[k][l] (column-wise, B side)
module operand_bank #(
    parameter int WIDTH     = 8,
    parameter int N         = 2,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(N*N)-1:0]     waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(3*N+1)-1:0]   t,
    output logic [N*WIDTH-1:0]         lanes
);

    logic [WIDTH-1:0] mem [N*N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < N * N; e++) begin
                mem[e] <= '0;
            end
        end else if (we && (32'(waddr) < N * N)) begin
            mem[waddr] <= wdata;
        end
    end

    // Lane l sees element k exactly when t == l + k, which avoids any
    // signed subtraction on the counter.
    always_comb begin
        lanes = '0;
        for (int l = 0; l < N; l++) begin
            for (int k = 0; k < N; k++) begin
                if (32'(t) == l + k) begin
                    lanes[l*WIDTH +: WIDTH] = TRANSPOSE ? mem[k*N + l] : mem[l*N + k];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand source for the NxN PE array. Holds an A tile and a B tile, and on
// start clears the array for one cycle and then streams skewed wavefronts so
// PE(i,j) accumulates sum_k A[i][k]*B[k][j].
//   clk, rst    : clock, synchronous active-high reset
//   load_valid  : element write request
//   load_ready  : high only while IDLE
//   load_sel    : 0 = A tile, 1 = B tile
//   load_addr   : row-major element index r*N+c
//   load_data   : signed element value
//   start       : begin a pass (only looked at in IDLE, never queued)
//   busy        : high during CLEAR/STREAM/DRAIN
//   done        : one-cycle pulse when PE c_out values are final
//   clear_out   : clear strobe to every PE
//   a_row       : lane i -> a_in of PE(i,0)
//   b_col       : lane j -> b_in of PE(0,j)
//
// Load handshake: an element is written on a clock edge where both
// load_valid and load_ready are high; load_valid may be held while
// load_ready is low and nothing happens until the feeder returns to IDLE.
//
// All outputs are registers decoded from the next state, so each output
// lines up with the state it describes. cnt holds the S-index of the
// current cycle (S0 = CLEAR); the wavefront read for S(t+1) uses t.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int WIDTH = FEED_WIDTH,
    parameter int N     = FEED_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    load_sel,
    input  logic [$clog2(N*N)-1:0]  load_addr,
    input  logic [WIDTH-1:0]        load_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    clear_out,
    output logic [N*WIDTH-1:0]      a_row,
    output logic [N*WIDTH-1:0]      b_col
);

    localparam int CW         = $clog2(3 * N + 1);
    localparam int STREAM_END = stream_len(N);
    localparam int DRAIN_END  = stream_len(N) + drain_len(N);

    feeder_state_t   state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic [CW-1:0]   rd_t;
    logic            wr_fire;
    logic [N*WIDTH-1:0] a_lanes, b_lanes;

    assign wr_fire = load_valid & load_ready;
    // Only meaningful when the next state is STREAM (next_cnt >= 1).
    assign rd_t    = next_cnt - CW'(1);

    operand_bank #(.WIDTH(WIDTH), .N(N), .TRANSPOSE(1'b0)) u_bank_a (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire & ~load_sel),
        .waddr (load_addr),
        .wdata (load_data),
        .t     (rd_t),
        .lanes (a_lanes)
    );

    operand_bank #(.WIDTH(WIDTH), .N(N), .TRANSPOSE(1'b1)) u_bank_b (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire & load_sel),
        .waddr (load_addr),
        .wdata (load_data),
        .t     (rd_t),
        .lanes (b_lanes)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CLEAR;
                    next_cnt   = '0;
                end
            end
            CLEAR: begin
                next_state = STREAM;
                next_cnt   = CW'(1);
            end
            STREAM: begin
                next_cnt = cnt + CW'(1);
                if (cnt == CW'(STREAM_END)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_cnt = cnt + CW'(1);
                if (cnt == CW'(DRAIN_END)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // load_ready mirrors "state is IDLE", so it comes out of reset high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            clear_out  <= 1'b0;
            load_ready <= 1'b1;
            a_row      <= '0;
            b_col      <= '0;
        end else begin
            state      <= next_state;
            cnt        <= next_cnt;
            busy       <= (next_state == CLEAR) || (next_state == STREAM) || (next_state == DRAIN);
            done       <= (next_state == DONE);
            clear_out  <= (next_state == CLEAR);
            load_ready <= (next_state == IDLE);
            a_row      <= (next_state == STREAM) ? a_lanes : '0;
            b_col      <= (next_state == STREAM) ? b_lanes : '0;
        end
    end

endmodule
